// File: rtl/lcd_pkg.sv
// Shared constants for the SPI LCD pixel path: panel geometry, RGB565 colours
// and the test-pattern encoding.
package lcd_pkg;

  localparam int LCD_H = 240;
  localparam int LCD_V = 135;
  localparam int CNT_W = 8;

  localparam logic [15:0] COL_WHITE   = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COL_CYAN    = 16'h07FF;
  localparam logic [15:0] COL_GREEN   = 16'h07E0;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;
  localparam logic [15:0] COL_RED     = 16'hF800;
  localparam logic [15:0] COL_BLUE    = 16'h001F;
  localparam logic [15:0] COL_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_raster_cnt.sv
// Raster position of the next pixel to emit: x/y plus a bar-width counter so bar
// index needs no divider. Updates one cycle after clear/advance; no backpressure of its own.
module lcd_raster_cnt
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H,
  parameter int V_ACTIVE = LCD_V
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [2:0]       bar,
  output logic             sof,
  output logic             eol,
  output logic             eof
);

  localparam int               BAR_W    = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, bw_q, bw_d;
  logic [2:0]       bar_q, bar_d;

  assign x   = x_q;
  assign y   = y_q;
  assign bar = bar_q;
  assign sof = (x_q == '0) && (y_q == '0);
  assign eol = (x_q == X_LAST);
  assign eof = eol && (y_q == Y_LAST);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    bw_d  = bw_q;
    bar_d = bar_q;
    if (clear) begin
      x_d   = '0;
      y_d   = '0;
      bw_d  = '0;
      bar_d = '0;
    end else if (advance) begin
      if (eol) begin
        x_d   = '0;
        bw_d  = '0;
        bar_d = '0;
        y_d   = (y_q == Y_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
        // H_ACTIVE is a multiple of 8, so the last bar ends exactly on eol
        if (bw_q == BAR_LAST) begin
          bw_d  = '0;
          bar_d = bar_q + 3'd1;
        end else begin
          bw_d = bw_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q   <= '0;
      y_q   <= '0;
      bw_q  <= '0;
      bar_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      bw_q  <= bw_d;
      bar_q <= bar_d;
    end
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// Raster-order RGB565 test-pattern source, one frame per start; first px_valid 2 clk after start.
// Output registers hold while px_valid && !px_ready; no bubbles while px_ready stays high.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int          H_ACTIVE    = LCD_H,
  parameter int          V_ACTIVE    = LCD_V,
  parameter int          CHECK_SHIFT = 3,
  parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  pattern,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [15:0] px_data,
  output logic        px_sof,
  output logic        px_eol,
  output logic        px_eof
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]  state_q, state_d;
  pat_e        pat_q, pat_d;
  logic [4:0]  fc_q, fc_d;
  logic        busy_q, busy_d, done_q, done_d, vld_q, vld_d;
  logic        sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0] data_q, data_d, pix;
  logic        load, cnt_clear, cnt_adv;

  logic [CNT_W-1:0] cx, cy, tile;
  logic [2:0]       cbar;
  logic             c_sof, c_eol, c_eof;
  logic             unused_tile;

  lcd_raster_cnt #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear),
    .advance(cnt_adv),
    .x      (cx),
    .y      (cy),
    .bar    (cbar),
    .sof    (c_sof),
    .eol    (c_eol),
    .eof    (c_eof)
  );

  // Only bit 0 of the tile index matters; the frame count flips the phase per frame
  assign tile        = (cx >> CHECK_SHIFT) ^ (cy >> CHECK_SHIFT) ^ CNT_W'(fc_q);
  assign unused_tile = ^tile[CNT_W-1:1];

  always_comb begin
    case (pat_q)
      PAT_BARS:  pix = bar_color(cbar);
      PAT_GRAD:  pix = {cx[7:3], cy[7:2], fc_q};
      PAT_CHECK: pix = tile[0] ? COL_WHITE : COL_BLACK;
      default:   pix = SOLID_COLOR;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    fc_d        = fc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    vld_d       = vld_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = data_q;
    sof_d       = sof_q;
    eol_d       = eol_q;
    eof_d       = eof_q;
    load        = 1'b0;
    cnt_clear   = 1'b0;
    cnt_adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d     = pat_e'(pattern);
          fc_d      = frame_cnt_q[4:0];
          busy_d    = 1'b1;
          cnt_clear = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        cnt_adv = 1'b1;
        vld_d   = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (px_ready) begin
          if (eof_q) begin
            vld_d       = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = ST_IDLE;
          end else begin
            load    = 1'b1;
            cnt_adv = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The raster counter runs one pixel ahead of the output registers
    if (load) begin
      data_d = pix;
      sof_d  = c_sof;
      eol_d  = c_eol;
      eof_d  = c_eof;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pat_q       <= PAT_BARS;
      fc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_q       <= 1'b0;
      frame_cnt_q <= '0;
      data_q      <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      fc_q        <= fc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;
  assign px_valid   = vld_q;
  assign px_data    = data_q;
  assign px_sof     = sof_q;
  assign px_eol     = eol_q;
  assign px_eof     = eof_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen on a 240x20 raster (full line width, short frame
// so every frame fits a small cycle budget).
module tb_lcd_pattern_gen;

  localparam int H    = 240;
  localparam int V    = 20;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  pattern;
  logic        busy, frame_done, px_valid, px_ready;
  logic [7:0]  frame_cnt;
  logic [15:0] px_data;
  logic        px_sof, px_eol, px_eof;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  tb_fc = 8'd0;
  logic [15:0] pix_log [NPIX];

  lcd_pattern_gen #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .CHECK_SHIFT(3),
    .SOLID_COLOR(16'hF800)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .pattern   (pattern),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_data   (px_data),
    .px_sof    (px_sof),
    .px_eol    (px_eol),
    .px_eof    (px_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input logic [1:0] p, input int x, input int y,
                                          input logic [7:0] fc);
    logic [7:0]  xb, yb;
    logic [15:0] c;
    xb = x[7:0];
    yb = y[7:0];
    case (p)
      2'd0: begin
        case (x / (H / 8))
          0: c = 16'hFFFF;
          1: c = 16'hFFE0;
          2: c = 16'h07FF;
          3: c = 16'h07E0;
          4: c = 16'hF81F;
          5: c = 16'hF800;
          6: c = 16'h001F;
          default: c = 16'h0000;
        endcase
      end
      2'd1: c = {xb[7:3], yb[7:2], fc[4:0]};
      2'd2: c = ((((x >> 3) ^ (y >> 3) ^ int'(fc)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: c = 16'hF800;
    endcase
    return c;
  endfunction

  // Runs one frame end to end, checking every handshaked pixel against the model.
  task automatic do_frame(input logic [1:0] pat, input bit rnd, input bit poke,
                          input bit prestarted, input bit chain, input logic [1:0] chain_pat);
    int          hs = 0, cyc = 0, lat = -1;
    int          data_err = 0, flag_err = 0, hold_err = 0, ctl_err = 0;
    int          tx = 0, ty = 0;
    bit          poked = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [18:0] pbundle = '0;
    logic [7:0]  fc;
    fc = tb_fc;
    if (!prestarted) begin
      start   = 1'b1;
      pattern = pat;
    end
    while (hs < NPIX && cyc < 4 * NPIX + 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (px_valid && lat < 0) lat = cyc;
      if (pv && !pr && {px_data, px_sof, px_eol, px_eof} !== pbundle) hold_err++;
      if (!busy || frame_done) ctl_err++;
      if (poke && hs == 100 && !poked) begin
        start   = 1'b1;
        pattern = ~pat;
        poked   = 1;
      end
      pr       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      px_ready = pr;
      if (px_valid && pr) begin
        if (px_data !== exp_pix(pat, tx, ty, fc)) data_err++;
        if ({px_sof, px_eol, px_eof} !== {(tx == 0 && ty == 0), (tx == H - 1),
                                           (tx == H - 1 && ty == V - 1)}) flag_err++;
        pix_log[hs] = px_data;
        hs++;
        if (tx == H - 1) begin
          tx = 0;
          ty++;
        end else begin
          tx++;
        end
      end
      pv      = px_valid;
      pbundle = {px_data, px_sof, px_eol, px_eof};
    end
    @(negedge clk);
    chk("handshakes", hs, NPIX);
    chk("start_latency", lat, 2);
    chk("pixel_data", data_err, 0);
    chk("pixel_flags", flag_err, 0);
    chk("hold_stable", hold_err, 0);
    chk("busy_in_frame", ctl_err, 0);
    chk("frame_done", frame_done, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("valid_after", px_valid, 1'b0);
    chk("frame_cnt", frame_cnt, fc + 8'd1);
    tb_fc = fc + 8'd1;
    if (chain) begin
      start   = 1'b1;
      pattern = chain_pat;
    end
  endtask

  initial begin
    int cnt, cyc;
    resetn   = 1'b0;
    start    = 1'b0;
    pattern  = 2'd0;
    px_ready = 1'b0;
    #23;
    chk("rst_valid", px_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
    chk("rst_data", px_data, 16'h0000);
    chk("rst_flags", {px_sof, px_eol, px_eof}, 3'b000);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Solid frame
    do_frame(2'd3, 0, 0, 0, 0, 2'd0);
    chk("solid_first", pix_log[0], 16'hF800);
    chk("solid_last", pix_log[NPIX-1], 16'hF800);

    // Colour bars, width 30
    do_frame(2'd0, 0, 0, 0, 0, 2'd0);
    chk("bar_x29", pix_log[29], 16'hFFFF);
    chk("bar_x30", pix_log[30], 16'hFFE0);
    chk("bar_x60", pix_log[60], 16'h07FF);
    chk("bar_x90", pix_log[90], 16'h07E0);
    chk("bar_x120", pix_log[120], 16'hF81F);
    chk("bar_x150", pix_log[150], 16'hF800);
    chk("bar_x180", pix_log[180], 16'h001F);
    chk("bar_x210", pix_log[210], 16'h0000);
    chk("bar_x239", pix_log[239], 16'h0000);
    chk("bar_y5_x30", pix_log[5*H+30], 16'hFFE0);
    chk("bar_y5_x0", pix_log[5*H], 16'hFFFF);

    // Gradient, third frame (fc=2): (239,19) = {29, 4, 2}
    do_frame(2'd1, 0, 0, 0, 0, 2'd0);
    chk("grad_00", pix_log[0], 16'h0002);
    chk("grad_last", pix_log[NPIX-1], 16'hE882);

    // Gradient (fc=3) with start and pattern change mid-frame, both ignored
    do_frame(2'd1, 0, 1, 0, 0, 2'd0);
    chk("poke_pix_200", pix_log[200], 16'hC803);

    // Checker (fc=4), random backpressure, chained start in the frame_done cycle
    do_frame(2'd2, 1, 0, 0, 1, 2'd3);
    chk("chk_8_0", pix_log[8], 16'hFFFF);
    chk("chk_8_8", pix_log[8*H+8], 16'h0000);
    chk("chk_0_0", pix_log[0], 16'h0000);
    do_frame(2'd3, 0, 0, 1, 0, 2'd0);

    // Asynchronous reset mid-frame
    start    = 1'b1;
    pattern  = 2'd2;
    px_ready = 1'b1;
    cnt      = 0;
    cyc      = 0;
    while (cnt < 1000 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (px_valid && px_ready) cnt++;
    end
    chk("pre_rst_pixels", cnt, 1000);
    chk("pre_rst_frame_cnt", frame_cnt, 8'd6);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", px_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_frame_cnt", frame_cnt, 8'd0);
    @(negedge clk);
    resetn = 1'b1;
    tb_fc  = 8'd0;
    @(negedge clk);
    do_frame(2'd0, 0, 0, 0, 0, 2'd0);
    chk("post_rst_first", pix_log[0], 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
